// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_chk_pkg.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_chk_pkg.sv - shared types and truth table for the nor3 cell checker
package gf180mcu_fd_sc_mcu7t5v0__nor3_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_FIN
   } state_t;

   localparam int NUM_PATTERNS = 8;

   // Pattern bit 0 drives A1, bit 1 A2, bit 2 A3; NOR is high only when all are low.
   function automatic logic expected_zn(input logic [2:0] pattern);
      return (pattern == 3'd0);
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_1.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_1.sv - behavioural view of the 3-input NOR library cell
module gf180mcu_fd_sc_mcu7t5v0__nor3_1 (
   input  logic A1,
   input  logic A2,
   input  logic A3,
   output logic ZN
);

   assign ZN = ~(A1 | A2 | A3);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_chk_top.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_chk_top.sv - checker wired to a nor3_1 cell instance
module gf180mcu_fd_sc_mcu7t5v0__nor3_chk_top #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             a1,
   output logic             a2,
   output logic             a3,
   output logic [ERR_W-1:0] err_cnt,
   output logic [7:0]       fail_vec
);

   logic zn;

   gf180mcu_fd_sc_mcu7t5v0__nor3_chk #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .LOOPS         (LOOPS),
      .ERR_W         (ERR_W)
   ) u_chk (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .a1       (a1),
      .a2       (a2),
      .a3       (a3),
      .zn       (zn),
      .err_cnt  (err_cnt),
      .fail_vec (fail_vec)
   );

   gf180mcu_fd_sc_mcu7t5v0__nor3_1 u_cell (
      .A1 (a1),
      .A2 (a2),
      .A3 (a3),
      .ZN (zn)
   );

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_chk.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_chk.sv - exerciser/checker stepping a nor3 cell through its truth table
module gf180mcu_fd_sc_mcu7t5v0__nor3_chk
   import gf180mcu_fd_sc_mcu7t5v0__nor3_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             a1,
   output logic             a2,
   output logic             a3,
   input  logic             zn,
   output logic [ERR_W-1:0] err_cnt,
   output logic [7:0]       fail_vec
);

   localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES);
   localparam logic [15:0]      LAST_LOOP   = 16'(LOOPS - 1);
   localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  settle_cnt;
   logic [2:0]  pattern;
   logic [15:0] loop_cnt;
   logic [2:0]  drive;
   logic        last_pattern;
   logic        mismatch;

   assign {a3, a2, a1} = drive;
   assign busy         = (state != ST_IDLE);
   assign last_pattern = (pattern == 3'(NUM_PATTERNS - 1)) && (loop_cnt == LAST_LOOP);
   // Case equality so an X or Z on the cell output is scored as a failure.
   assign mismatch     = !(zn === expected_zn(pattern));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_DRIVE;
         ST_DRIVE:  state_nxt = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
         ST_SETTLE: if (settle_cnt <= 8'd1) state_nxt = ST_SAMPLE;
         ST_SAMPLE: state_nxt = last_pattern ? ST_FIN : ST_DRIVE;
         ST_FIN:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         settle_cnt <= 8'd0;
         pattern    <= 3'd0;
         loop_cnt   <= 16'd0;
         drive      <= 3'd0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         fail_vec   <= 8'h00;
      end else begin
         state <= state_nxt;
         // Registered so DONE rises on the same edge that takes the FSM back to IDLE.
         done  <= (state == ST_FIN);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  err_cnt  <= '0;
                  fail_vec <= 8'h00;
                  pass     <= 1'b0;
                  pattern  <= 3'd0;
                  loop_cnt <= 16'd0;
               end
            end
            ST_DRIVE: begin
               drive      <= pattern;
               settle_cnt <= SETTLE_INIT;
            end
            ST_SETTLE: begin
               settle_cnt <= settle_cnt - 8'd1;
            end
            ST_SAMPLE: begin
               if (mismatch) begin
                  if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
                  fail_vec[pattern] <= 1'b1;
               end
               if (!last_pattern) begin
                  pattern <= pattern + 3'd1;
                  if (pattern == 3'(NUM_PATTERNS - 1)) loop_cnt <= loop_cnt + 16'd1;
               end
            end
            ST_FIN: begin
               drive <= 3'd0;
               pass  <= (err_cnt == '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor3_chk.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor3_chk.sv - scoreboard bench for the nor3 cell checker
module tb_gf180mcu_fd_sc_mcu7t5v0__nor3_chk;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            stuck_a;
   logic [4:0]      start_v;
   logic [4:0]      busy_v;
   logic [4:0]      done_v;
   logic [4:0]      pass_v;
   logic [4:0][2:0] a_v;
   logic [7:0]      err_a, err_b, err_d, err_e;
   logic [3:0]      err_c;
   logic [7:0]      fv_a, fv_b, fv_c, fv_d, fv_e;
   logic            zn_a, zn_b, zn_c, zn_d;

   assign zn_a = stuck_a ? 1'b1 : ~(|a_v[0]);
   assign zn_b = 1'b0;
   assign zn_c = 1'b1;
   assign zn_d = ~(|a_v[3]);

   gf180mcu_fd_sc_mcu7t5v0__nor3_chk #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .pass(pass_v[0]), .a1(a_v[0][0]), .a2(a_v[0][1]), .a3(a_v[0][2]), .zn(zn_a),
      .err_cnt(err_a), .fail_vec(fv_a));

   gf180mcu_fd_sc_mcu7t5v0__nor3_chk #(.SETTLE_CYCLES(2), .LOOPS(3), .ERR_W(8)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .pass(pass_v[1]), .a1(a_v[1][0]), .a2(a_v[1][1]), .a3(a_v[1][2]), .zn(zn_b),
      .err_cnt(err_b), .fail_vec(fv_b));

   gf180mcu_fd_sc_mcu7t5v0__nor3_chk #(.SETTLE_CYCLES(2), .LOOPS(4), .ERR_W(4)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .pass(pass_v[2]), .a1(a_v[2][0]), .a2(a_v[2][1]), .a3(a_v[2][2]), .zn(zn_c),
      .err_cnt(err_c), .fail_vec(fv_c));

   gf180mcu_fd_sc_mcu7t5v0__nor3_chk #(.SETTLE_CYCLES(0), .LOOPS(1), .ERR_W(8)) u_dut_d (
      .clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
      .pass(pass_v[3]), .a1(a_v[3][0]), .a2(a_v[3][1]), .a3(a_v[3][2]), .zn(zn_d),
      .err_cnt(err_d), .fail_vec(fv_d));

   gf180mcu_fd_sc_mcu7t5v0__nor3_chk_top #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) u_top_e (
      .clk(clk), .rst(rst), .start(start_v[4]), .busy(busy_v[4]), .done(done_v[4]),
      .pass(pass_v[4]), .a1(a_v[4][0]), .a2(a_v[4][1]), .a3(a_v[4][2]),
      .err_cnt(err_e), .fail_vec(fv_e));

   typedef struct {
      int lat;
      int err;
      int fv;
      int pass;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_passed = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic int get_err(input int idx);
      case (idx)
         0: return int'(err_a);
         1: return int'(err_b);
         2: return int'(err_c);
         3: return int'(err_d);
         default: return int'(err_e);
      endcase
   endfunction

   function automatic int get_fv(input int idx);
      case (idx)
         0: return int'(fv_a);
         1: return int'(fv_b);
         2: return int'(fv_c);
         3: return int'(fv_d);
         default: return int'(fv_e);
      endcase
   endfunction

   // Launch one run, push its expected verdict, then pop and score it when DONE appears.
   task automatic run(input int idx, input int lat, input int err, input int fv,
                      input int pass, input int poke_at);
      exp_t e;
      int   cnt;
      bit   seen;
      e.lat = lat; e.err = err; e.fv = fv; e.pass = pass;
      sb.push_back(e);
      @(negedge clk);
      start_v[idx] = 1'b1;
      @(negedge clk);
      start_v[idx] = 1'b0;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 2000) begin
         @(negedge clk);
         cnt++;
         start_v[idx] = (cnt == poke_at);
         if (idx == 3)
            check($sformatf("a_seq_%0d", cnt), int'(a_v[3]),
                  (cnt >= 1 && cnt <= 16) ? (cnt - 1) / 2 : 0);
         if (done_v[idx]) seen = 1'b1;
      end
      start_v[idx] = 1'b0;
      e = sb.pop_front();
      check($sformatf("done_seen_%0d", idx), int'(seen), 1);
      check($sformatf("latency_%0d", idx), cnt, e.lat);
      check($sformatf("err_cnt_%0d", idx), get_err(idx), e.err);
      check($sformatf("fail_vec_%0d", idx), get_fv(idx), e.fv);
      check($sformatf("pass_%0d", idx), int'(pass_v[idx]), e.pass);
      check($sformatf("busy_at_done_%0d", idx), int'(busy_v[idx]), 0);
      @(negedge clk);
      check($sformatf("done_width_%0d", idx), int'(done_v[idx]), 0);
   endtask

   initial begin
      int  wait_cnt;
      bit  found;
      rst     = 1'b1;
      stuck_a = 1'b0;
      start_v = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy_v[0]), 0);
      check("rst_done", int'(done_v[0]), 0);
      check("rst_pass", int'(pass_v[0]), 0);
      check("rst_err", int'(err_a), 0);
      check("rst_fv", int'(fv_a), 0);
      check("rst_a", int'(a_v[0]), 0);
      rst = 1'b0;
      @(negedge clk);

      run(0, 33, 0, 8'h00, 1, -1);
      stuck_a = 1'b1;
      run(0, 33, 7, 8'hFE, 0, -1);
      run(1, 97, 3, 8'h01, 0, -1);
      run(2, 129, 4'hF, 8'hFE, 0, -1);
      run(3, 17, 0, 8'h00, 1, 5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_requeue", int'(busy_v[3]), 0);
      end
      run(4, 33, 0, 8'h00, 1, -1);

      // Abandon a stuck-at-1 run once pattern 4 is on the pins.
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      found    = 1'b0;
      wait_cnt = 0;
      while (!found && wait_cnt < 200) begin
         @(negedge clk);
         wait_cnt++;
         if (a_v[0] == 3'd4) found = 1'b1;
      end
      check("reach_p4", int'(found), 1);
      check("pre_rst_err", int'(err_a), 3);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", int'(busy_v[0]), 0);
      check("midrst_done", int'(done_v[0]), 0);
      check("midrst_err", int'(err_a), 0);
      check("midrst_fv", int'(fv_a), 0);
      check("midrst_a", int'(a_v[0]), 0);
      rst = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_v[0]) found = 1'b1;
      end
      check("no_done_after_rst", int'(found), 0);
      stuck_a = 1'b0;
      run(0, 33, 0, 8'h00, 1, -1);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__nor3_chk.md
# gf180mcu_fd_sc_mcu7t5v0__nor3_chk

On-chip exerciser and checker for the 3-input NOR cells of the 7-track library (nor3_1/2/4). It drives A1/A2/A3 through all 8 input patterns, waits a programmable settle time, samples ZN against the NOR truth table, and reports a pass/fail verdict, a saturating error count and a per-pattern failure map. It sits in the library's silicon-characterisation / BIST wrapper, on the opposite side of the cell's pins from the cell itself.

## Interface
Parameters:
- SETTLE_CYCLES, 2: idle cycles between driving a pattern and sampling ZN; 0 allowed, 0..255.
- LOOPS, 1: full 8-pattern passes per run; 1..65535.
- ERR_W, 8: width of ERR_CNT.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  run request; sampled only in IDLE.
- BUSY  output  1  high from the cycle after START is accepted until DONE.
- DONE  output  1  one-cycle pulse at end of run.
- PASS  output  1  ERR_CNT==0; valid from DONE until next accepted START.
- A1, A2, A3  output  1 each  registered drive to cell inputs.
- ZN  input  1  cell output under test.
- ERR_CNT  output  ERR_W  mismatch count, saturates at all-ones.
- FAIL_VEC  output  8  bit p set if pattern p ever mismatched.

## Operation
- Pattern index p (3-bit): A1=p[0], A2=p[1], A3=p[2]; expected ZN = (p==0).
- States: IDLE, DRIVE, SETTLE, SAMPLE, FIN.
- IDLE: A*=0. START=1 → clear ERR_CNT, FAIL_VEC, PASS; p=0, loop=0; → DRIVE.
- DRIVE: load A* from p; settle counter = SETTLE_CYCLES; → SETTLE, or → SAMPLE if SETTLE_CYCLES==0.
- SETTLE: decrement; at 1 → SAMPLE.
- SAMPLE: compare ZN to expected; on mismatch (X/Z counts as mismatch) ERR_CNT+=1 (saturating), FAIL_VEC[p]=1. p==7 and loop==LOOPS-1 → FIN; else p+=1 (wraps 7→0, loop+=1) → DRIVE.
- FIN: DONE=1, PASS updated, A*=0; → IDLE.
- START while BUSY or in FIN: ignored, no queuing.

## Timing
- Reset values: A1=A2=A3=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0, state IDLE.
- RST mid-run: next edge returns to reset values; no DONE pulse; run is abandoned.
- A* change on the DRIVE→next edge and hold through SAMPLE. ZN is sampled SETTLE_CYCLES+1 edges after A* change.
- Per pattern: SETTLE_CYCLES+2 cycles. Run: START-accept edge to DONE high = LOOPS·8·(SETTLE_CYCLES+2) + 1 cycles.
- BUSY falls in the same cycle DONE rises; DONE lasts exactly one cycle; back-to-back START accepted the cycle after DONE.
- Saturation: ERR_CNT holds at 2^ERR_W−1; FAIL_VEC is unaffected by saturation.
- ZN is combinational from registered A*; no synchroniser; the cell must settle within SETTLE_CYCLES+1 periods.

## Structure
- Package gf180mcu_fd_sc_mcu7t5v0__nor3_chk_pkg: state enum, NUM_PATTERNS=8, expected-ZN function of p.
- Checker is flat: FSM, settle counter, pattern/loop counters, error logic.
- One sub-module: gf180mcu_fd_sc_mcu7t5v0__nor3_chk_top wraps the checker with a gf180mcu_fd_sc_mcu7t5v0__nor3_1 instance wired A*↔A*, ZN↔ZN; bench and silicon wrapper use it.

## Test plan
- Good cell, SETTLE_CYCLES=2, LOOPS=1: START pulse → DONE exactly 33 cycles after accept edge, PASS=1, ERR_CNT=0, FAIL_VEC=8'h00.
- ZN forced stuck-at-0, LOOPS=3 → ERR_CNT=3, FAIL_VEC=8'h01, PASS=0.
- ZN forced stuck-at-1, LOOPS=1 → ERR_CNT=7, FAIL_VEC=8'hFE, PASS=0.
- ERR_W=4, stuck-at-1, LOOPS=4 (28 errors) → ERR_CNT=4'hF, FAIL_VEC=8'hFE.
- SETTLE_CYCLES=0, good cell → A* sequence 0..7 each held 2 cycles, DONE 17 cycles after accept, PASS=1; START re-pulsed during BUSY has no effect.
- RST asserted at pattern 4 → next edge all outputs at reset values, no DONE; a new START then runs a clean full pass with PASS=1.
